// File: rtl/m6502_bus_arbiter.sv
// Two-requester (CPU, DMA) arbiter onto one shared 8-bit memory bus, one access in flight.
// Optional macro M6502_ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed DMA priority.
module m6502_bus_arbiter #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rd_req,
   input  logic              cpu_wr_en,
   input  logic [7:0]        cpu_wr_data,
   output logic [7:0]        cpu_rd_data,
   output logic              cpu_ready,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic              dma_rd_req,
   input  logic              dma_wr_en,
   input  logic [7:0]        dma_wr_data,
   output logic [7:0]        dma_rd_data,
   output logic              dma_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_req,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   input  logic [7:0]        mem_rd_data,
   input  logic              mem_ready
);

   localparam int NP = 2;   // port 0 = CPU, port 1 = DMA

   typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT} state_t;

   state_t             state_reg;
   logic               grant_reg;
   logic               winner;
   logic               access_done;
   logic [NP-1:0]      req;
   logic [NP-1:0]      wr_req;
   logic [NP-1:0]      pending;
   logic [NP-1:0]      is_write;
   logic [NP-1:0]      clear;
   logic [ADDR_W-1:0]  addr_in   [NP];
   logic [7:0]         wdata_in  [NP];
   logic [ADDR_W-1:0]  addr_cap  [NP];
   logic [7:0]         wdata_cap [NP];
   logic [7:0]         rdata_cap [NP];

   assign req         = {dma_rd_req | dma_wr_en, cpu_rd_req | cpu_wr_en};
   assign wr_req      = {dma_wr_en, cpu_wr_en};
   assign addr_in[0]  = cpu_addr;
   assign addr_in[1]  = dma_addr;
   assign wdata_in[0] = cpu_wr_data;
   assign wdata_in[1] = dma_wr_data;

   // The granted port finishes either on an accepted write or after the read data cycle.
   assign access_done = ((state_reg == ISSUE) && mem_ready && mem_wr_en) ||
                        (state_reg == READ_WAIT);

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         logic              pending_reg;
         logic              write_reg;
         logic [ADDR_W-1:0] addr_reg;
         logic [7:0]        wdata_reg;
         logic [7:0]        rdata_reg;

         assign clear[gi] = access_done && (grant_reg == 1'(gi));

         // Clear wins over a new request, so a pulse on the completing edge is dropped.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               pending_reg <= 1'b0;
               write_reg   <= 1'b0;
               addr_reg    <= '0;
               wdata_reg   <= '0;
               rdata_reg   <= '0;
            end else begin
               if (clear[gi]) begin
                  pending_reg <= 1'b0;
               end else if (!pending_reg && req[gi]) begin
                  pending_reg <= 1'b1;
                  write_reg   <= wr_req[gi];
                  addr_reg    <= addr_in[gi];
                  wdata_reg   <= wdata_in[gi];
               end
               if ((state_reg == READ_WAIT) && (grant_reg == 1'(gi))) begin
                  rdata_reg <= mem_rd_data;
               end
            end
         end

         assign pending[gi]   = pending_reg;
         assign is_write[gi]  = write_reg;
         assign addr_cap[gi]  = addr_reg;
         assign wdata_cap[gi] = wdata_reg;
         assign rdata_cap[gi] = rdata_reg;
      end
   endgenerate

`ifdef M6502_ARB_ROUND_ROBIN_EN
   // grant_reg doubles as the last-grant record: on contention the other port wins.
   always_comb begin
      winner = pending[1];
      if (&pending) begin
         winner = ~grant_reg;
      end
   end
`else
   always_comb begin
      winner = pending[1];
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         grant_reg   <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         mem_rd_req  <= 1'b0;
         mem_wr_en   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|pending) begin
                  grant_reg   <= winner;
                  mem_addr    <= addr_cap[winner];
                  mem_wr_data <= wdata_cap[winner];
                  mem_rd_req  <= ~is_write[winner];
                  mem_wr_en   <= is_write[winner];
                  state_reg   <= ISSUE;
               end else begin
                  mem_rd_req <= 1'b0;
                  mem_wr_en  <= 1'b0;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  mem_rd_req <= 1'b0;
                  mem_wr_en  <= 1'b0;
                  state_reg  <= mem_wr_en ? IDLE : READ_WAIT;
               end
            end
            READ_WAIT: begin
               state_reg <= IDLE;
            end
            default: begin
               mem_rd_req <= 1'b0;
               mem_wr_en  <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

   assign cpu_ready   = ~pending[0];
   assign dma_ready   = ~pending[1];
   assign cpu_rd_data = rdata_cap[0];
   assign dma_rd_data = rdata_cap[1];

endmodule

// File: tb/tb_m6502_bus_arbiter.sv
// Directed bench for m6502_bus_arbiter (default fixed-priority build) with a one-cycle-latency memory model.
module tb_m6502_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] cpu_addr, dma_addr, mem_addr;
   logic        cpu_rd_req, cpu_wr_en, dma_rd_req, dma_wr_en;
   logic [7:0]  cpu_wr_data, dma_wr_data, cpu_rd_data, dma_rd_data;
   logic        cpu_ready, dma_ready;
   logic        mem_rd_req, mem_wr_en, mem_ready;
   logic [7:0]  mem_wr_data, mem_rd_data;

   int n_cmp = 0;
   int n_err = 0;
   int acc_cnt = 0;
   int acc0;
   logic [15:0] last_wr_addr = '0;
   logic [7:0]  last_wr_data = '0;

   m6502_bus_arbiter #(.ADDR_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_addr(cpu_addr), .cpu_rd_req(cpu_rd_req), .cpu_wr_en(cpu_wr_en),
      .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready),
      .dma_addr(dma_addr), .dma_rd_req(dma_rd_req), .dma_wr_en(dma_wr_en),
      .dma_wr_data(dma_wr_data), .dma_rd_data(dma_rd_data), .dma_ready(dma_ready),
      .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_en(mem_wr_en),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] data_for(input logic [15:0] a);
      case (a)
         16'hFFFC: data_for = 8'h34;
         16'h1000: data_for = 8'h11;
         16'h2000: data_for = 8'h22;
         default:  data_for = a[15:8] ^ a[7:0] ^ 8'hC3;
      endcase
   endfunction

   // Memory: read data valid the cycle after the accepted read cycle.
   always @(posedge clk) begin
      if (mem_rd_req && mem_ready) mem_rd_data <= data_for(mem_addr);
      if (mem_wr_en && mem_ready) begin
         last_wr_addr <= mem_addr;
         last_wr_data <= mem_wr_data;
      end
      if (reset_n && mem_ready && (mem_rd_req || mem_wr_en)) acc_cnt <= acc_cnt + 1;
   end

   always @(negedge clk) begin
      if (reset_n) begin
         n_cmp++;
         assert (!(mem_rd_req && mem_wr_en)) else begin
            n_err++;
            $error("FAIL strobe_excl: observed rd=%0b wr=%0b expected not both", mem_rd_req, mem_wr_en);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
      dma_rd_req = 1'b0; dma_wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      cpu_addr = '0; dma_addr = '0; cpu_wr_data = '0; dma_wr_data = '0;
      idle_inputs();
      mem_ready = 1'b1;
      mem_rd_data = '0;
      tick(); tick();
      chk("rst_cpu_ready", cpu_ready, 1);
      chk("rst_dma_ready", dma_ready, 1);
      chk("rst_cpu_rd_data", cpu_rd_data, 0);
      chk("rst_dma_rd_data", dma_rd_data, 0);
      chk("rst_mem_rd_req", mem_rd_req, 0);
      chk("rst_mem_wr_en", mem_wr_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wr_data", mem_wr_data, 0);
      reset_n = 1'b1;

      // CPU read pulse FFFC
      cpu_addr = 16'hFFFC; cpu_rd_req = 1'b1;
      tick(); idle_inputs();
      chk("rd_c1_ready", cpu_ready, 0);
      chk("rd_c1_strobe", mem_rd_req, 0);
      tick();
      chk("rd_c2_strobe", mem_rd_req, 1);
      chk("rd_c2_addr", mem_addr, 16'hFFFC);
      chk("rd_c2_wr", mem_wr_en, 0);
      tick();
      chk("rd_c3_strobe", mem_rd_req, 0);
      chk("rd_c3_ready", cpu_ready, 0);
      tick();
      chk("rd_c4_data", cpu_rd_data, 8'h34);
      chk("rd_c4_ready", cpu_ready, 1);
      chk("rd_c4_dma_data", dma_rd_data, 0);
      $display("txn cpu_read addr=FFFC data=%h", cpu_rd_data);

      // DMA write with mem_ready low for three strobe cycles
      dma_addr = 16'h0200; dma_wr_data = 8'hA5; dma_wr_en = 1'b1; mem_ready = 1'b0;
      tick(); idle_inputs();
      chk("wr_c1_ready", dma_ready, 0);
      for (int c = 2; c <= 5; c++) begin
         tick();
         if (c == 5) mem_ready = 1'b1;
         chk($sformatf("wr_c%0d_strobe", c), mem_wr_en, 1);
         chk($sformatf("wr_c%0d_addr", c), mem_addr, 16'h0200);
         chk($sformatf("wr_c%0d_data", c), mem_wr_data, 8'hA5);
         chk($sformatf("wr_c%0d_ready", c), dma_ready, 0);
      end
      tick();
      chk("wr_c6_ready", dma_ready, 1);
      chk("wr_c6_strobe", mem_wr_en, 0);
      chk("wr_mem_data", last_wr_data, 8'hA5);
      chk("wr_mem_addr", last_wr_addr, 16'h0200);
      $display("txn dma_write addr=0200 data=A5 stalled=3");

      // Simultaneous reads: DMA first, then CPU
      cpu_addr = 16'h1000; cpu_rd_req = 1'b1;
      dma_addr = 16'h2000; dma_rd_req = 1'b1;
      tick(); idle_inputs();
      tick();
      chk("con_c2_addr", mem_addr, 16'h2000);
      chk("con_c2_strobe", mem_rd_req, 1);
      tick(); tick();
      chk("con_c4_dma_data", dma_rd_data, 8'h22);
      chk("con_c4_dma_ready", dma_ready, 1);
      chk("con_c4_cpu_ready", cpu_ready, 0);
      chk("con_c4_cpu_data", cpu_rd_data, 8'h34);
      tick();
      chk("con_c5_addr", mem_addr, 16'h1000);
      chk("con_c5_strobe", mem_rd_req, 1);
      tick(); tick();
      chk("con_c7_cpu_data", cpu_rd_data, 8'h11);
      chk("con_c7_cpu_ready", cpu_ready, 1);
      chk("con_c7_dma_data", dma_rd_data, 8'h22);
      $display("txn contention dma=%h cpu=%h", dma_rd_data, cpu_rd_data);

      // Second CPU pulses while busy (including the clearing edge) are ignored
      acc0 = acc_cnt;
      cpu_addr = 16'h0300; cpu_rd_req = 1'b1;
      tick(); idle_inputs();
      tick();
      chk("ign_c2_addr", mem_addr, 16'h0300);
      cpu_addr = 16'h0400; cpu_rd_req = 1'b1;
      tick();
      chk("ign_c3_ready", cpu_ready, 0);
      tick(); idle_inputs();
      chk("ign_c4_data", cpu_rd_data, data_for(16'h0300));
      chk("ign_c4_ready", cpu_ready, 1);
      tick();
      chk("ign_c5_strobe", mem_rd_req, 0);
      tick();
      chk("ign_c6_strobe", mem_rd_req, 0);
      chk("ign_access_cnt", acc_cnt, acc0 + 1);
      $display("txn cpu_read_ignored_repeat accesses=%0d", acc_cnt - acc0);

      // rd_req and wr_en together act as a write
      cpu_addr = 16'h0700; cpu_wr_data = 8'h77; cpu_rd_req = 1'b1; cpu_wr_en = 1'b1;
      tick(); idle_inputs();
      tick();
      chk("both_c2_wr", mem_wr_en, 1);
      chk("both_c2_rd", mem_rd_req, 0);
      chk("both_c2_addr", mem_addr, 16'h0700);
      tick();
      chk("both_c3_ready", cpu_ready, 1);
      chk("both_mem_data", last_wr_data, 8'h77);
      $display("txn cpu_rdwr_as_write addr=0700 data=77");

      // Reset during READ_WAIT
      cpu_addr = 16'h0500; cpu_rd_req = 1'b1;
      tick(); idle_inputs();
      tick(); tick();
      #2 reset_n = 1'b0;
      #1;
      chk("arst_cpu_ready", cpu_ready, 1);
      chk("arst_cpu_data", cpu_rd_data, 0);
      chk("arst_dma_data", dma_rd_data, 0);
      chk("arst_mem_rd", mem_rd_req, 0);
      chk("arst_mem_addr", mem_addr, 0);
      tick();
      reset_n = 1'b1;
      dma_addr = 16'h0600; dma_wr_data = 8'h3C; dma_wr_en = 1'b1;
      tick(); idle_inputs();
      chk("post_c1_ready", dma_ready, 0);
      tick();
      chk("post_c2_strobe", mem_wr_en, 1);
      chk("post_c2_addr", mem_addr, 16'h0600);
      tick();
      chk("post_c3_ready", dma_ready, 1);
      chk("post_cpu_data", cpu_rd_data, 0);
      chk("post_mem_data", last_wr_data, 8'h3C);
      $display("txn reset_in_read_wait then dma_write addr=0600 data=3C");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/m6502_bus_arbiter.md
M6502_BUS_ARBITER -- requirements
Module: m6502_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, address width of all address ports.
REQ-002 clk  in  1  single clock for all logic; rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 cpu_addr  in  ADDR_W  CPU access address.
REQ-005 cpu_rd_req  in  1  CPU read request (may be a one-cycle pulse).
REQ-006 cpu_wr_en  in  1  CPU write request (may be a one-cycle pulse).
REQ-007 cpu_wr_data  in  8  CPU write data.
REQ-008 cpu_rd_data  out  8  registered CPU read data.
REQ-009 cpu_ready  out  1  high = CPU port idle / last access complete.
REQ-010 dma_addr, dma_rd_req, dma_wr_en, dma_wr_data, dma_rd_data, dma_ready: same directions, widths and meanings as the cpu_* ports, for the DMA requester.
REQ-011 mem_addr  out  ADDR_W  shared bus address.
REQ-012 mem_rd_req / mem_wr_en  out  1 each  shared bus strobes.
REQ-013 mem_wr_data  out  8  shared bus write data.
REQ-014 mem_rd_data  in  8  valid the cycle after the accepted read cycle.
REQ-015 mem_ready  in  1  memory accepts the presented access in any cycle it is high.

Function
REQ-016 Each port SHALL own a one-deep capture register (addr, data, type, pending); a cycle with rd_req|wr_en and pending=0 SHALL set pending at the next edge.
REQ-017 A request while pending=1 (including the clearing edge) SHALL be ignored; rd_req and wr_en both high SHALL be treated as a write.
REQ-018 X_ready SHALL equal NOT pending of that port.
REQ-019 The FSM SHALL have states IDLE, ISSUE, READ_WAIT.
REQ-020 IDLE: if any port is pending, select winner, register its addr/data/strobe onto mem_* and go to ISSUE; otherwise hold mem strobes at 0.
REQ-021 ISSUE: mem_* held stable until a cycle with mem_ready=1; then read -> READ_WAIT, write -> clear winner pending, drop strobes, go to IDLE.
REQ-022 READ_WAIT: capture mem_rd_data into winner's X_rd_data, clear winner pending, go to IDLE; the other port's rd_data SHALL be unchanged.
REQ-023 Strobes SHALL be high in exactly one accepted cycle per access; the two ports SHALL never be driven onto mem_* simultaneously.
REQ-024 Uncontended latency, mem_ready=1, request in cycle 0: read -> strobe cycle 2, X_ready=1 with data valid cycle 4; write -> strobe cycle 2, X_ready=1 cycle 3.
REQ-025 Default arbitration SHALL be fixed priority, DMA over CPU, evaluated only in IDLE; grant SHALL not change before completion.
REQ-026 mem_addr SHALL wrap naturally within ADDR_W; no arithmetic on addresses.

Reset
REQ-027 reset_n low SHALL asynchronously force: state IDLE, both pending 0, cpu_ready=dma_ready=1, cpu_rd_data=dma_rd_data=0, mem_rd_req=mem_wr_en=0, mem_addr=0, mem_wr_data=0, last grant=CPU.
REQ-028 Reset during ISSUE or READ_WAIT SHALL abandon the access; in-flight read data is discarded and no ready pulse is produced.

Configuration
REQ-029 Macro M6502_ARB_ROUND_ROBIN_EN: defined -> on simultaneous pending, the port not granted last wins (last-grant register updated at each grant); undefined -> fixed DMA priority per REQ-025 and no last-grant register.

Verification
REQ-030 Reset then CPU read pulse addr 16'hFFFC, memory returns 8'h34 -> mem_rd_req cycle 2, cpu_rd_data=8'h34 and cpu_ready=1 cycle 4.
REQ-031 DMA write 16'h0200 data 8'hA5, mem_ready low 3 cycles -> mem_wr_en/addr/data held stable 4 cycles, dma_ready=1 the cycle after acceptance.
REQ-032 CPU read 16'h1000 and DMA read 16'h2000 in same cycle -> DMA served first, CPU second; each rd_data holds its own byte (8'h11 / 8'h22).
REQ-033 With M6502_ARB_ROUND_ROBIN_EN, continuous DMA requests plus one CPU request -> CPU granted at next IDLE; without macro, CPU waits until DMA pending clears.
REQ-034 Second CPU pulse while cpu_ready=0 -> ignored, exactly one mem access observed.
REQ-035 reset_n low during READ_WAIT -> all outputs at REQ-027 values immediately, FSM resumes cleanly on next request.
